// File: rtl/nios2_hex_scroll_ctrl.sv
// Avalon-MM HEX message scroller: a 16-entry segment buffer shown statically or
// scrolled right-to-left across HEX5..HEX0, with a done interrupt per full pass.
module nios2_hex_scroll_ctrl #(
   parameter int          DEPTH = 16,
   parameter logic [7:0]  BLANK = 8'hFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic [7:0]  hex0,
   output logic [7:0]  hex1,
   output logic [7:0]  hex2,
   output logic [7:0]  hex3,
   output logic [7:0]  hex4,
   output logic [7:0]  hex5
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(DEPTH + 6);
   localparam int IW = PW + 1;

   logic [2:0]    ctrl;
   logic [23:0]   rate;
   logic [23:0]   presc;
   logic [CW-1:0] count, count_nx;
   logic [PW-1:0] pos, last;
   logic          ovf, done;
   logic [7:0]    buffer [DEPTH];
   logic [7:0]    seg [6];
   logic [5:0][7:0] hex_q;
   logic [IW-1:0] len;

   logic wr, wr_ctrl, wr_rate, wr_data, wr_stat, clear;
   logic full, data_ok, running, tick, wrap, reload;
   logic unused_wd;

   assign unused_wd = ^writedata[31:24];

   assign wr      = chipselect & ~write_n;
   assign wr_ctrl = wr && (address == 3'd0);
   assign wr_rate = wr && (address == 3'd1);
   assign wr_data = wr && (address == 3'd2);
   assign wr_stat = wr && (address == 3'd3);
   assign clear   = wr && (address == 3'd4);

   assign full     = (count == CW'(DEPTH));
   assign data_ok  = wr_data & ~full;
   assign count_nx = clear ? '0 : count + CW'(data_ok);

   // Tick compares against the length including a same-cycle DATA append.
   assign running = ctrl[0] & ctrl[1] & (count != '0);
   assign tick    = running & (presc == '0) & ~clear;
   assign last    = PW'(count_nx) + PW'(5);
   assign wrap    = tick & (pos == last);

   // Prescaler restarts whenever the block goes from not-ticking to run (and run&scroll).
   assign reload = wr_ctrl & writedata[0] &
                   (~ctrl[0] | (writedata[1] & ~(ctrl[0] & ctrl[1])));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl  <= '0;
         rate  <= '0;
         presc <= '0;
         count <= '0;
         pos   <= '0;
         ovf   <= 1'b0;
         done  <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl <= writedata[2:0];
         if (wr_rate) rate <= writedata[23:0];
         count <= count_nx;

         if (wr_data && full)             ovf <= 1'b1;
         else if (wr_stat && writedata[7]) ovf <= 1'b0;

         if (wrap)                         done <= 1'b1;
         else if (wr_stat && writedata[8]) done <= 1'b0;

         if (clear || reload)  presc <= rate;
         else if (running)     presc <= (presc == '0) ? rate : presc - 24'd1;

         if (clear || !ctrl[1] || count == '0) pos <= '0;
         else if (tick)                         pos <= wrap ? '0 : pos + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (data_ok) buffer[count[AW-1:0]] <= writedata[7:0];
   end

   // Digit k shows v[(pos+k) mod L]; v is buffer[0..count-1] followed by six blanks.
   assign len = IW'(count) + IW'(6);

   for (genvar k = 0; k < 6; k++) begin : g_dig
      logic [IW-1:0] idx_raw, idx;
      assign idx_raw = IW'(pos) + IW'(k);
      assign idx     = (idx_raw >= len) ? idx_raw - len : idx_raw;
      assign seg[k]  = (idx < IW'(count)) ? buffer[idx[AW-1:0]] : BLANK;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hex_q <= {6{BLANK}};
      end else begin
         for (int k = 0; k < 6; k++) hex_q[k] <= seg[k];
      end
   end

   assign hex5 = hex_q[0];
   assign hex4 = hex_q[1];
   assign hex3 = hex_q[2];
   assign hex2 = hex_q[3];
   assign hex1 = hex_q[4];
   assign hex0 = hex_q[5];

   assign irq = done & ctrl[2];

   always_comb begin
      readdata = '0;
      case (address)
         3'd0: readdata[2:0]  = ctrl;
         3'd1: readdata[23:0] = rate;
         3'd3: begin
            readdata[4:0] = 5'(count);
            readdata[5]   = full;
            readdata[6]   = (count == '0);
            readdata[7]   = ovf;
            readdata[8]   = done;
         end
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_nios2_hex_scroll_ctrl.sv
// Directed bench for the HEX scroller: expected values queued at stimulus time,
// popped and compared against the DUT at sample points.
module tb_nios2_hex_scroll_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        irq;
   logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
   logic [47:0] hexv;

   logic [63:0] sb[$];
   int checks = 0;
   int errors = 0;

   nios2_hex_scroll_ctrl dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
   );

   always #5 clk = ~clk;
   assign hexv = {hex5, hex4, hex3, hex2, hex1, hex0};

   task automatic expect_v(input logic [63:0] v);
      sb.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs);
      logic [63:0] exp;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s no expected value queued, observed %h", tag, obs);
      end else begin
         exp = sb.pop_front();
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] r;

      // Reset state
      idle(2);
      reset_n = 1'b1;
      idle(1);
      expect_v(64'hFFFF_FFFF_FFFF);  chk("reset_hex", {16'h0, hexv});
      expect_v(64'h040);             rd(3'd3, r); chk("reset_status", {32'h0, r});
      expect_v(64'h0);               chk("reset_irq", {63'h0, irq});

      // Static display
      wr(3'd2, 32'hC0); wr(3'd2, 32'hF9); wr(3'd2, 32'hA4);
      wr(3'd0, 32'h1);
      expect_v(64'h003);             rd(3'd3, r); chk("static_status", {32'h0, r});
      idle(1);
      expect_v(64'hC0F9_A4FF_FFFF);  chk("static_hex", {16'h0, hexv});

      // Scroll, RATE=1 -> tick every 2 cycles, L=9
      wr(3'd1, 32'h1);
      expect_v(64'h1);               rd(3'd1, r); chk("rate_rd", {32'h0, r});
      wr(3'd0, 32'h0);
      wr(3'd0, 32'h7);               // n=0: prescaler loaded
      idle(3);
      expect_v(64'hF9A4_FFFF_FFFF);  chk("scroll_pos1", {16'h0, hexv});
      idle(2);
      expect_v(64'hA4FF_FFFF_FFFF);  chk("scroll_pos2", {16'h0, hexv});
      idle(12);                      // n=17: eight ticks so far
      expect_v(64'h0);               chk("scroll_irq_before_wrap", {63'h0, irq});
      idle(1);                       // n=18: ninth tick wrapped
      expect_v(64'h1);               chk("scroll_irq_after_wrap", {63'h0, irq});
      expect_v(64'h103);             rd(3'd3, r); chk("scroll_status_done", {32'h0, r});
      expect_v(64'hFFC0_F9A4_FFFF);  chk("scroll_hex_pos8", {16'h0, hexv});
      wr(3'd3, 32'h100);             // n=19
      expect_v(64'h0);               chk("done_clear_irq", {63'h0, irq});

      // CLEAR mid-scroll at pos=4
      idle(7);                       // n=26: pos=4
      expect_v(64'hFFFF_FFFF_FFC0);  chk("scroll_pos4_hex", {16'h0, hexv});
      wr(3'd4, 32'h0);
      expect_v(64'h040);             rd(3'd3, r); chk("clear_status", {32'h0, r});
      idle(1);
      expect_v(64'hFFFF_FFFF_FFFF);  chk("clear_hex", {16'h0, hexv});
      idle(4);
      expect_v(64'hFFFF_FFFF_FFFF);  chk("clear_hex_hold", {16'h0, hexv});
      wr(3'd2, 32'h92);
      idle(1);
      expect_v(64'h92FF_FFFF_FFFF);  chk("clear_push_hex", {16'h0, hexv});

      // Overflow
      wr(3'd0, 32'h0);
      wr(3'd4, 32'h0);
      for (int i = 0; i < 16; i++) wr(3'd2, 32'(i));
      wr(3'd2, 32'h55);
      expect_v(64'h0B0);             rd(3'd3, r); chk("ovf_status", {32'h0, r});
      idle(1);
      expect_v(64'h0001_0203_0405);  chk("ovf_hex", {16'h0, hexv});
      wr(3'd3, 32'h80);
      expect_v(64'h030);             rd(3'd3, r); chk("ovf_clear_status", {32'h0, r});

      // Full-buffer scroll to wrap (L=22), then async reset
      wr(3'd0, 32'h7);               // n=0
      idle(44);                      // 22nd tick at n=44
      expect_v(64'h1);               chk("full_wrap_irq", {63'h0, irq});
      expect_v(64'h130);             rd(3'd3, r); chk("full_wrap_status", {32'h0, r});
      expect_v(64'hFF00_0102_0304);  chk("full_wrap_hex", {16'h0, hexv});
      idle(3);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      expect_v(64'hFFFF_FFFF_FFFF);  chk("async_rst_hex", {16'h0, hexv});
      expect_v(64'h0);               chk("async_rst_irq", {63'h0, irq});
      expect_v(64'h040);             rd(3'd3, r); chk("async_rst_status", {32'h0, r});
      expect_v(64'h0);               rd(3'd0, r); chk("async_rst_ctrl", {32'h0, r});
      idle(1);
      reset_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

endmodule
